// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the clock divider bank
//
// Purpose : board frequency, standard terminal counts and the channel-index
//           width helper used by clk_div_bank and clk_div_channel.
// Ports   : none (package).
package clk_div_pkg;

  // Board reference clock feeding clk_in.
  localparam int unsigned BOARD_HZ = 100_000_000;

  // Terminal counts M for common rates; clk_out = BOARD_HZ / (2*(M+1)).
  localparam int unsigned DIV_1MHZ = 49;
  localparam int unsigned DIV_1HZ  = 49_999_999;

  // Width of a channel index; never zero so a single-channel bank still
  // has a legal one-bit cfg_ch port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one programmable divider channel
//
// Purpose : counts clk_in cycles up to a loadable terminal count, toggling a
//           square wave and pulsing a one-cycle tick on every terminal count.
// Ports   : clk_in   - board clock
//           reset    - asynchronous, active-high
//           en       - count enable; when low cnt and clk_out hold
//           restart  - zero cnt/clk_out/tick, keep terminal count
//           load     - write load_val into the terminal count and restart
//           load_val - new terminal count M
//           clk_out  - square wave, period 2*(M+1) cycles
//           tick     - one-cycle pulse every M+1 enabled cycles
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_MAX = 49
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] max_r;

  // cnt is zeroed whenever max_r changes, so cnt can never pass max_r and an
  // equality test is enough to find the terminal count.
  logic at_max;
  assign at_max = (cnt == max_r);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      max_r   <= CNT_W'(DEFAULT_MAX);
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      // The terminal-count write lands even when a restart comes with it.
      if (load) begin
        max_r <= load_val;
      end

      if (restart || load) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (en) begin
        if (at_max) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel runtime-programmable clock divider
//
// Purpose : NUM_CH independent dividers of clk_in with per-channel enables,
//           per-channel terminal-count writes and a common re-phase.
// Ports   : clk_in  - board clock (100 MHz)
//           reset   - asynchronous, active-high
//           en      - per-channel count enable
//           sync    - restart every channel on this edge
//           cfg_we  - terminal-count write strobe
//           cfg_ch  - channel index for the write (indices >= NUM_CH ignored)
//           cfg_max - new terminal count M
//           clk_out - per-channel square wave, period 2*(M+1) cycles
//           tick    - per-channel one-cycle pulse, period M+1 cycles
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_MAX = 49
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      sync,
  input  logic                      cfg_we,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]          cfg_max,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // An out-of-range cfg_ch matches no channel, so the write is dropped.
    assign load[i] = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_MAX (DEFAULT_MAX)
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .en       (en[i]),
      .restart  (sync),
      .load     (load[i]),
      .load_val (cfg_max),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule
